led_seq_scheduler: RTL
======================

Name: led_seq_scheduler

Overview:
- Pattern controller for the board LED bank: four ring LEDs plus one center LED, driven from the 12 MHz board clock.
- Generates the step rate and sequences the ring through one of four patterns.
- Accepts mode-change requests and applies them only on step boundaries.
- Applies PWM brightness gating to the ring; the center LED shows when a mode change is pending.

Parameters:
- STEP_DIV, 3000000, clocks per pattern step (4 steps/s at 12 MHz); must be >= 2.
- PWM_BITS, 4, width of the brightness input and of the PWM counter.

Ports:
- clk  input  1  board clock.
- rst_n  input  1  asynchronous active-low reset.
- mode_req  input  2  requested mode: 0 ROTATE, 1 BOUNCE, 2 BLINK, 3 FILL.
- mode_req_valid  input  1  one-cycle strobe qualifying mode_req.
- pause  input  1  level; freezes the prescaler and the pattern state.
- brightness  input  PWM_BITS  ring duty.
- led_ring  output  4  ring LEDs, registered.
- led_center  output  1  high while a mode request is pending, registered.
- mode_cur  output  2  active mode.
- step_tick  output  1  one-cycle pulse on each pattern advance.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: led_ring=0000, led_center=0, mode_cur=0, step_tick=0.
  - Internal state: prescaler=0, step index=0, bounce direction=up, pending invalid, PWM counter=0.
- Prescaler:
  - Counts 0..STEP_DIV-1 while pause=0 and holds its value while pause=1.
  - step_tick=1 in the cycle where count==STEP_DIV-1 and pause=0; the counter wraps to 0 on that edge.
- Pattern state:
  - Advances on the edge that ends a step_tick cycle.
  - led_ring reflects the new state one clock later.
- Mode sequences (index 0 first):
  - ROTATE: idx 0..3, pattern 1<<idx, 3 wraps to 0.
  - BOUNCE: pos 0..3 with direction; the direction flips at pos 3 (to down) and pos 0 (to up). Sequence 0001,0010,0100,1000,0100,0010,0001,0010...
  - BLINK: idx toggles 0/1; patterns 1111/0000.
  - FILL: idx 0..4, pattern (1<<idx)-1, 4 wraps to 0. Sequence 0000,0001,0011,0111,1111,0000.
- Mode handshake:
  - A valid request with mode_req != mode_cur loads the pending register; the latest request wins.
  - A valid request with mode_req == mode_cur clears pending.
  - On a step_tick, if pending was valid before that cycle, mode_cur takes the pending mode, idx resets to 0, direction resets to up, and pending clears. That tick does not advance the old pattern.
  - A request arriving in the same cycle as step_tick is not applied at that tick; it becomes pending and applies on the next tick.
  - led_center equals pending-valid, delayed one register.
- PWM:
  - Free-running PWM_BITS counter, never paused.
  - Ring gate is on when brightness is all ones, or when pwm_cnt < brightness.
  - led_ring = pattern AND gate, registered.
  - brightness=0 gives a dark ring while stepping continues.
- Pause:
  - No step_tick is issued, and pattern, pending and mode are held.
  - PWM keeps running.
  - New requests are still accepted into pending.
- Reset mid-operation: outputs clear immediately, without waiting for a clock edge. After release, ring shows the ROTATE step 0 pattern one clock later.

Decomposition:
- Package led_seq_pkg holds:
  - mode encodings MODE_ROTATE, MODE_BOUNCE, MODE_BLINK, MODE_FILL;
  - FILL_LAST=4 and RING_W=4;
  - a function mapping (mode, idx) to the 4-bit pattern.
- Sub-module led_step_prescaler (clk, rst_n, pause, tick) with parameter STEP_DIV.
- The mode FSM, the PWM logic and the output registers stay in the top level.

Test Plan (STEP_DIV=4, PWM_BITS=4):
- Reset then release, brightness=15 -> led_ring=0001 one clock after release; step_tick every 4 clocks; sequence 0001,0010,0100,1000,0001; mode_cur=0.
- mode_req=1 strobe mid-step -> led_center=1 until the next tick, then mode_cur=1; ring 0001,0010,0100,1000,0100,0010,0001.
- Request 3, then request 2 before the tick -> mode_cur=2; ring 1111,0000,1111. Then request 3 -> 0000,0001,0011,0111,1111,0000.
- Request 1 in the same cycle as step_tick -> not applied at that tick, applied at the following tick. Request 1 then request 0 while in mode 0 -> pending cleared, led_center=0, no mode change.
- pause=1 for 10 clocks with a pending request -> no step_tick, led_ring pattern frozen, led_center=1. On release, the tick arrives after the remaining prescaler count and the mode is applied.
- brightness=4 -> a lit ring LED is high 4 of every 16 clocks. brightness=0 -> ring 0000 while step_tick continues. Assert rst_n=0 mid-step -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequence scheduler.
// Holds the mode encodings, the ring geometry and the function that turns
// (mode, step index) into a ring pattern.
package led_seq_pkg;

  localparam int RING_W    = 4;
  localparam int FILL_LAST = 4;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  // ROTATE and BOUNCE share the one-hot map; BOUNCE differs only in how idx moves.
  function automatic logic [RING_W-1:0] pattern_of(mode_e m, logic [2:0] idx);
    logic [RING_W:0] fill;
    fill       = '0;
    pattern_of = '0;
    case (m)
      MODE_ROTATE,
      MODE_BOUNCE: pattern_of = RING_W'(1) << idx[1:0];
      MODE_BLINK:  pattern_of = idx[0] ? '0 : '1;
      MODE_FILL: begin
        // one extra bit so idx=4 yields 1_0000 - 1 = 0_1111
        fill       = ((RING_W+1)'(1) << idx) - (RING_W+1)'(1);
        pattern_of = fill[RING_W-1:0];
      end
      default:     pattern_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/led_seq_scheduler_prescaler.sv
// Step-rate prescaler.
// Ports: clk, rst_n (async low), pause (holds the count), tick (one-cycle
// pulse in the last count of each step, suppressed while paused).
module led_step_prescaler #(
  parameter int STEP_DIV = 3000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause,
  output logic tick
);

  localparam int            CW   = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = !pause && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (!pause) r_cnt <= tick ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/led_seq_scheduler.sv
// LED bank pattern controller: four ring LEDs plus a center LED.
// Ports:
//   clk, rst_n      board clock, async active-low reset
//   mode_req[1:0]   requested mode, qualified by mode_req_valid strobe
//   pause           freezes the prescaler and pattern state (PWM keeps running)
//   brightness      ring PWM duty
//   led_ring[3:0]   gated ring pattern, registered
//   led_center      mode request pending, registered
//   mode_cur[1:0]   active mode
//   step_tick       one-cycle pulse on each pattern advance
module led_seq_scheduler
  import led_seq_pkg::*;
#(
  parameter int STEP_DIV = 3000000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode_req,
  input  logic                mode_req_valid,
  input  logic                pause,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [RING_W-1:0]   led_ring,
  output logic                led_center,
  output logic [1:0]          mode_cur,
  output logic                step_tick
);

  logic w_tick;

  led_step_prescaler #(.STEP_DIV(STEP_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .pause (pause),
    .tick  (w_tick)
  );

  mode_e       r_mode,     w_mode_nxt;
  logic [2:0]  r_idx,      w_idx_nxt;
  logic        r_dir_dn,   w_dir_nxt;
  logic        r_pend_vld, w_pend_vld_nxt;
  mode_e       r_pend_mode, w_pend_mode_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= MODE_ROTATE;
      r_idx       <= '0;
      r_dir_dn    <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_mode <= MODE_ROTATE;
    end else begin
      r_mode      <= w_mode_nxt;
      r_idx       <= w_idx_nxt;
      r_dir_dn    <= w_dir_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_mode <= w_pend_mode_nxt;
    end
  end

  always_comb begin
    w_mode_nxt      = r_mode;
    w_idx_nxt       = r_idx;
    w_dir_nxt       = r_dir_dn;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_mode_nxt = r_pend_mode;

    if (w_tick) begin
      if (r_pend_vld) begin
        // a mode switch consumes the tick instead of advancing the old pattern
        w_mode_nxt     = r_pend_mode;
        w_idx_nxt      = '0;
        w_dir_nxt      = 1'b0;
        w_pend_vld_nxt = 1'b0;
      end else begin
        case (r_mode)
          MODE_ROTATE: w_idx_nxt = {1'b0, r_idx[1:0] + 2'd1};
          MODE_BOUNCE: begin
            if (!r_dir_dn) begin
              if (r_idx == 3'd3) begin
                w_dir_nxt = 1'b1;
                w_idx_nxt = 3'd2;
              end else begin
                w_idx_nxt = r_idx + 3'd1;
              end
            end else begin
              if (r_idx == 3'd0) begin
                w_dir_nxt = 1'b0;
                w_idx_nxt = 3'd1;
              end else begin
                w_idx_nxt = r_idx - 3'd1;
              end
            end
          end
          MODE_BLINK:  w_idx_nxt = {2'b00, ~r_idx[0]};
          MODE_FILL:   w_idx_nxt = (r_idx == 3'(FILL_LAST)) ? 3'd0 : r_idx + 3'd1;
          default:     w_idx_nxt = '0;
        endcase
      end
    end

    // Requests are sampled after the tick decision, so a request landing on a
    // tick only becomes pending and waits for the following tick.
    if (mode_req_valid) begin
      if (mode_req != r_mode) begin
        w_pend_vld_nxt  = 1'b1;
        w_pend_mode_nxt = mode_e'(mode_req);
      end else begin
        w_pend_vld_nxt  = 1'b0;
      end
    end
  end

  // PWM: free-running, never paused; full scale forces the gate fully on.
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_gate;

  assign w_gate = (&brightness) || (r_pwm_cnt < brightness);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt  <= '0;
      led_ring   <= '0;
      led_center <= 1'b0;
    end else begin
      r_pwm_cnt  <= r_pwm_cnt + 1'b1;
      led_ring   <= pattern_of(r_mode, r_idx) & {RING_W{w_gate}};
      led_center <= r_pend_vld;
    end
  end

  assign mode_cur  = r_mode;
  assign step_tick = w_tick;

endmodule
